simd_multiplier_pipelined: RTL and testbench

- Parametrised, pipelined, precision-configurable multiplier. It is the successor to the fixed 9x9 half-mode multipliers in the PIRDSP datapath.
- One WIDTH x WIDTH array is split at run time into 1, 2 or 4 independent lanes, each with selectable signed/unsigned operands.
- Stall-capable valid/ready pipeline of PIPE_STAGES registers. Mode and sign are carried with each transaction, so the mode may change every cycle.
- Sits between the operand registers and the accumulator/post-adder.

---
 rtl/simd_multiplier_pipelined.sv | 182 ++++++++++++++++++
 tb/tb_simd_multiplier_pipelined.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_multiplier_pipelined.sv
// simd_multiplier_pipelined: precision-configurable WIDTH x WIDTH multiplier.
// The array is split at run time into 1, 2 or 4 independent lanes with
// per-operand signedness, behind a stall-capable valid/ready pipeline of
// PIPE_STAGES registers. Mode and signs travel with each transaction.
module simd_multiplier_pipelined #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 A_sign,
  input  logic                 B_sign,
  input  logic [1:0]           MODE,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   C,
  output logic [1:0]           out_mode
);

  localparam int unsigned NS = PIPE_STAGES;
  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned QW = WIDTH / 4;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'b00,
    MODE_HALF    = 2'b01,
    MODE_QUARTER = 2'b10
  } lane_mode_e;

  // Stage occupancy and per-stage load enables.
  logic [NS-1:0] v_q;
  logic [NS-1:0] ld;
  logic [NS-1:0] low_mask;

  // Stage 0 holds the registered operands of the transaction.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             as_q;
  logic             bs_q;
  lane_mode_e       mode_q;
  lane_mode_e       mode_d;

  // Lane products computed from the stage 0 operands.
  logic [2*WIDTH-1:0]        mul_c;
  logic signed [2*WIDTH-1:0] af;
  logic signed [2*WIDTH-1:0] bf;
  logic signed [2*WIDTH-1:0] pf;
  logic signed [WIDTH-1:0]   ah;
  logic signed [WIDTH-1:0]   bh;
  logic signed [WIDTH-1:0]   ph;
  logic signed [2*QW-1:0]    aq;
  logic signed [2*QW-1:0]    bq;
  logic signed [2*QW-1:0]    pq;

  // Stage s loads when it or any stage downstream of it has room, or the
  // output drains; unrolled so no bit of ld depends on another bit of ld.
  always_comb begin
    ld       = '0;
    low_mask = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      low_mask = (NS'(1) << s) - NS'(1);
      ld[s]    = out_ready | ~&(v_q | low_mask);
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[NS-1];

  // Reserved MODE=11 behaves as full width and reports full width.
  always_comb begin
    case (MODE)
      2'b01:   mode_d = MODE_HALF;
      2'b10:   mode_d = MODE_QUARTER;
      default: mode_d = MODE_FULL;
    endcase
  end

  // Valid bits advance through the pipe; bubbles are squeezed out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else begin
      if (ld[0]) v_q[0] <= in_valid;
      for (int unsigned s = 1; s < NS; s++) begin
        if (ld[s]) v_q[s] <= v_q[s-1];
      end
    end
  end

  // Operand capture on transfer only, so empty-stage data stays zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      as_q   <= 1'b0;
      bs_q   <= 1'b0;
      mode_q <= MODE_FULL;
    end else if (ld[0] && in_valid) begin
      a_q    <= A;
      b_q    <= B;
      as_q   <= A_sign;
      bs_q   <= B_sign;
      mode_q <= mode_d;
    end
  end

  // Each lane is sign- or zero-extended to its full product width, so the
  // truncated product is exact and never spills into a neighbouring lane.
  always_comb begin
    mul_c = '0;
    af    = '0;
    bf    = '0;
    pf    = '0;
    ah    = '0;
    bh    = '0;
    ph    = '0;
    aq    = '0;
    bq    = '0;
    pq    = '0;
    case (mode_q)
      MODE_HALF: begin
        for (int unsigned k = 0; k < 2; k++) begin
          ah = {{HW{as_q & a_q[k*HW+HW-1]}}, a_q[k*HW +: HW]};
          bh = {{HW{bs_q & b_q[k*HW+HW-1]}}, b_q[k*HW +: HW]};
          ph = ah * bh;
          mul_c[k*WIDTH +: WIDTH] = ph;
        end
      end
      MODE_QUARTER: begin
        for (int unsigned k = 0; k < 4; k++) begin
          aq = {{QW{as_q & a_q[k*QW+QW-1]}}, a_q[k*QW +: QW]};
          bq = {{QW{bs_q & b_q[k*QW+QW-1]}}, b_q[k*QW +: QW]};
          pq = aq * bq;
          mul_c[k*2*QW +: 2*QW] = pq;
        end
      end
      default: begin
        af    = {{WIDTH{as_q & a_q[WIDTH-1]}}, a_q};
        bf    = {{WIDTH{bs_q & b_q[WIDTH-1]}}, b_q};
        pf    = af * bf;
        mul_c = pf;
      end
    endcase
  end

  if (NS > 1) begin : g_pipe
    logic [2*WIDTH-1:0] prod_q  [NS-1];
    logic [1:0]         pmode_q [NS-1];

    // Product stages 1..NS-1 carry the result and its mode to the output.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int unsigned s = 0; s < NS - 1; s++) begin
          prod_q[s]  <= '0;
          pmode_q[s] <= '0;
        end
      end else begin
        if (ld[1] && v_q[0]) begin
          prod_q[0]  <= mul_c;
          pmode_q[0] <= mode_q;
        end
        for (int unsigned s = 2; s < NS; s++) begin
          if (ld[s] && v_q[s-1]) begin
            prod_q[s-1]  <= prod_q[s-2];
            pmode_q[s-1] <= pmode_q[s-2];
          end
        end
      end
    end

    assign C        = prod_q[NS-2];
    assign out_mode = pmode_q[NS-2];
  end else begin : g_single
    assign C        = mul_c;
    assign out_mode = mode_q;
  end

endmodule

// File: tb/tb_simd_multiplier_pipelined.sv
// Self-checking bench for simd_multiplier_pipelined (WIDTH=16, PIPE_STAGES=3).
module tb_simd_multiplier_pipelined;

  localparam int W = 16;
  localparam int P = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           A_sign;
  logic           B_sign;
  logic [1:0]     MODE;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] C;
  logic [1:0]     out_mode;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2*W-1:0] c;
    logic [1:0]     m;
    int             t;
  } exp_t;

  exp_t exp_q[$];

  simd_multiplier_pipelined #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .A_sign(A_sign), .B_sign(B_sign), .MODE(MODE),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .out_mode(out_mode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: each lane interpreted as an integer, multiplied, wrapped to 2*LW bits.
  function automatic logic [2*W-1:0] model_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic as, input logic bs, input logic [1:0] mode);
    int     lanes;
    int     lw;
    longint av, bv, p;
    logic [2*W-1:0] r;
    lanes = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
    lw    = W / lanes;
    r     = '0;
    for (int k = 0; k < lanes; k++) begin
      av = (longint'(a) >> (k*lw)) & ((64'sd1 << lw) - 1);
      bv = (longint'(b) >> (k*lw)) & ((64'sd1 << lw) - 1);
      if (as && ((av >> (lw-1)) & 1) == 1) av = av - (64'sd1 << lw);
      if (bs && ((bv >> (lw-1)) & 1) == 1) bv = bv - (64'sd1 << lw);
      p = (av * bv) & ((64'sd1 << (2*lw)) - 1);
      r = r | (2*W)'(p << (k*2*lw));
    end
    return r;
  endfunction

  function automatic logic [1:0] model_m(input logic [1:0] mode);
    return (mode == 2'b11) ? 2'b00 : mode;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic as, input logic bs, input logic [1:0] m);
    in_valid = v; A = a; B = b; A_sign = as; B_sign = bs; MODE = m;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (C !== '0) begin errors++; $display("FAIL reset_C: got %h want 0", C); end
    checks++; if (out_mode !== 2'b00) begin errors++; $display("FAIL reset_out_mode: got %b want 00", out_mode); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (C !== '0) begin errors++; $display("FAIL idle_C: got %h want 0", C); end
  endtask

  task automatic test_directed();
    logic [W-1:0]   ta [6];
    logic [W-1:0]   tb [6];
    logic           tas[6];
    logic           tbs[6];
    logic [1:0]     tm [6];
    logic [2*W-1:0] tc [6];
    logic [1:0]     tom[6];
    int n;
    ta[0]=16'hFFFF; tb[0]=16'h0002; tas[0]=1; tbs[0]=1; tm[0]=2'b00; tc[0]=32'hFFFFFFFE; tom[0]=2'b00;
    ta[1]=16'hFFFF; tb[1]=16'h0002; tas[1]=0; tbs[1]=0; tm[1]=2'b00; tc[1]=32'h0001FFFE; tom[1]=2'b00;
    ta[2]=16'h8003; tb[2]=16'h02FD; tas[2]=1; tbs[2]=1; tm[2]=2'b01; tc[2]=32'hFF00FFF7; tom[2]=2'b01;
    ta[3]=16'hF321; tb[3]=16'h2F11; tas[3]=0; tbs[3]=0; tm[3]=2'b10; tc[3]=32'h1E2D0201; tom[3]=2'b10;
    ta[4]=16'hF321; tb[4]=16'h2F11; tas[4]=1; tbs[4]=0; tm[4]=2'b10; tc[4]=32'hFE2D0201; tom[4]=2'b10;
    ta[5]=16'h8000; tb[5]=16'h8000; tas[5]=1; tbs[5]=1; tm[5]=2'b11; tc[5]=32'h40000000; tom[5]=2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ta[i], tb[i], tas[i], tbs[i], tm[i]);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (n !== P-1) begin errors++; $display("FAIL dir%0d_latency: got %0d edges want %0d", i, n, P-1); end
      checks++; if (C !== tc[i]) begin errors++; $display("FAIL dir%0d_C: got %h want %h", i, C, tc[i]); end
      checks++; if (out_mode !== tom[i]) begin errors++; $display("FAIL dir%0d_mode: got %b want %b", i, out_mode, tom[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int pops = 0;
    out_ready = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 4 + P + 3; k++) begin
      if (k < 4) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 2'(k));
      else       in_valid = 1'b0;
      @(negedge clk);
      if (k < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
      end
      if (in_valid && in_ready) begin
        e.c = model_c(A, B, A_sign, B_sign, MODE); e.m = model_m(MODE); e.t = cyc; exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra: C=%h with nothing outstanding", C); end
        else begin
          e = exp_q.pop_front(); pops++;
          if (C !== e.c || out_mode !== e.m) begin
            errors++; $display("FAIL b2b_data: got %h/%b want %h/%b", C, out_mode, e.c, e.m);
          end
          checks++; if (cyc - e.t !== P) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", cyc - e.t, P); end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (pops !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", pops); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta[6];
    logic [W-1:0] tb[6];
    logic [1:0]   tm[6];
    logic         ts[6];
    exp_t e;
    int sent = 0;
    int pops = 0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      ta[i] = W'($urandom); tb[i] = W'($urandom); tm[i] = 2'($urandom); ts[i] = 1'($urandom);
    end
    for (int k = 0; k < 40 && pops < 6; k++) begin
      out_ready = (k < 2 || k >= 10);
      if (sent < 6) drive(1'b1, ta[sent], tb[sent], ts[sent], ~ts[sent], tm[sent]);
      else          in_valid = 1'b0;
      @(negedge clk);
      if (k == 9) begin
        checks++; if (sent !== 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      end
      if (out_valid && !out_ready && exp_q.size() > 0) begin
        checks++;
        if (C !== exp_q[0].c || out_mode !== exp_q[0].m) begin
          errors++; $display("FAIL bp_stall_stable: got %h/%b want %h/%b", C, out_mode, exp_q[0].c, exp_q[0].m);
        end
      end
      if (in_valid && in_ready) begin
        e.c = model_c(A, B, A_sign, B_sign, MODE); e.m = model_m(MODE); e.t = cyc; exp_q.push_back(e); sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: C=%h with nothing outstanding", C); end
        else begin
          e = exp_q.pop_front(); pops++;
          if (C !== e.c || out_mode !== e.m) begin
            errors++; $display("FAIL bp_data: got %h/%b want %h/%b", C, out_mode, e.c, e.m);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (pops !== 6) begin errors++; $display("FAIL bp_count: got %0d want 6", pops); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic [2*W-1:0] want;
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1, 2'b00);
      @(negedge clk);
      if (!in_ready) break;
      @(posedge clk); #1;
    end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_fill: in_ready %b out_valid %b want 0/1", in_ready, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (C !== '0 || out_mode !== 2'b00) begin errors++; $display("FAIL rst_mid_C: got %h/%b want 0/00", C, out_mode); end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h00F0, 1'b0, 1'b1, 2'b01);
    want = model_c(16'h1234, 16'h00F0, 1'b0, 1'b1, 2'b01);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_post_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== P-1) begin errors++; $display("FAIL rst_post_latency: got %0d want %0d", n, P-1); end
    checks++; if (C !== want || out_mode !== 2'b01) begin errors++; $display("FAIL rst_post_C: got %h/%b want %h/01", C, out_mode, want); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_post_stale: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random();
    exp_t e;
    int k;
    exp_q.delete();
    k = 0;
    while (k < 400 && (k < 300 || exp_q.size() > 0)) begin
      out_ready = (k >= 300) ? 1'b1 : ($urandom_range(2) != 0);
      if (k < 300) drive($urandom_range(3) != 0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
      else         in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        e.c = model_c(A, B, A_sign, B_sign, MODE); e.m = model_m(MODE); e.t = cyc; exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra: C=%h with nothing outstanding", C); end
        else begin
          e = exp_q.pop_front();
          if (C !== e.c || out_mode !== e.m) begin
            errors++; $display("FAIL rnd_data: got %h/%b want %h/%b", C, out_mode, e.c, e.m);
          end
        end
      end
      @(posedge clk); #1;
      k++;
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_drain: %0d results missing", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
